ps2_key_mmio: RTL and testbench
===============================

Name: ps2_key_mmio

Overview:
Memory-mapped keyboard event port that replaces the single-word keyboard write slot in data memory with a buffered, bus-readable event queue. It decodes PS/2 scan-code prefixes into tagged key events and buffers them in a parametrised FIFO. The CPU pops events through word-addressed registers. The block also provides NUM_MIRROR CPU-writable words that are exported continuously to display logic, for example credit/money values and reel states.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
BASE_ADDR, 10, word address of register offset 0
NUM_MIRROR, 2, number of exported 32-bit mirror registers, 1..8
FILTER_BREAK, 0, 1 = discard release (break) events before the FIFO

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
kb_valid  in  1  one-cycle strobe: kb_code holds a new byte from the PS/2 receiver
kb_code  in  8  received scan-code byte
bus_we  in  1  CPU write strobe
bus_re  in  1  CPU read strobe
bus_addr  in  32  word address
bus_wd  in  32  write data
bus_rd  out  32  read data, registered
mirror_out  out  32*NUM_MIRROR  mirror word i is at bits [32i+31:32i]
key_pending  out  1  FIFO not empty
overflow  out  1  sticky overflow flag

Behaviour:
- Reset: the following are cleared on the rising edge of clk with rst=1: FIFO pointers, count, overflow, bus_rd, all mirrors, prefix FSM (returns to IDLE). key_pending=0 and overflow=0 the cycle after reset. Reset mid-prefix discards the partial sequence.
- Prefix FSM, advanced only when kb_valid=1:
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; any other byte -> push {ext=0, rel=0, code} and stay in IDLE.
  - GOT_E0: F0 -> GOT_E0F0; other byte -> push {1,0,code} and go to IDLE.
  - GOT_F0: any byte -> push {0,1,code} and go to IDLE.
  - GOT_E0F0: any byte -> push {1,1,code} and go to IDLE.
  - E1 is treated as an ordinary code.
  - FILTER_BREAK=1: events with rel=1 are not pushed, but the FSM still returns to IDLE.
- FIFO entry is 10 bits: {ext, rel, code[7:0]}. A push is written on the same edge as the kb_valid cycle that completes the sequence.
- Register map, word offsets from BASE_ADDR:
  - 0 STATUS (read-only): bit0 not_empty, bit1 full, bit2 overflow, bits[16:8] count, other bits 0.
  - 1 DATA: a read returns {22'b0, ext, rel, code} of the head entry and pops it. If the FIFO is empty, the read returns 0 and does not pop. A write has no effect.
  - 2 CONTROL (write-only, reads 0): bit0=1 clears overflow; bit1=1 flushes the FIFO (pointers and count to 0).
  - 4..4+NUM_MIRROR-1 MIRROR[i]: read/write. A write updates mirror_out on the next edge.
  - Any other address, including unused offsets: reads 0, writes ignored.
- Read latency: 1 cycle. bus_rd is valid the cycle after bus_re and holds its value until the next bus_re. The pop occurs on the bus_re edge.
- bus_we and bus_re asserted together to the same address: the write takes effect and the read returns the pre-write value.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because a slot is freed on the same edge; no overflow.
  - When empty, the read returns 0 and the push is accepted, giving count=1.
- Push when full with no pop: the event is dropped and overflow is set. overflow stays set until cleared by a CONTROL bit0 write or reset.
- Push and CONTROL flush on the same edge: the flush wins and count=0.
- Overflow set and CONTROL clear on the same edge: set wins.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH. full = (count==DEPTH).

Test Plan:
1. Reset, then kb_valid bytes 1C, F0 1C, E0 75, E0 F0 75; read offset 1 four times -> bus_rd = 0x01C, 0x11C, 0x275, 0x375 each one cycle after bus_re; then STATUS = 0.
2. FILTER_BREAK=1, same byte stream -> only 0x01C and 0x275 are queued; count=2.
3. DEPTH=16: push 17 single-byte codes 01..11 -> STATUS full=1, count=16, overflow=1; pops return 01..10 in order; CONTROL write 0x1 -> overflow=0.
4. FIFO full, then push and DATA read on the same edge -> read returns the oldest code, count stays 16, overflow=0; then FIFO empty with push and read on the same edge -> bus_rd=0, count=1.
5. Write 0x000003E8 to offset 4 and 0x5 to offset 5 -> mirror_out = {0x00000005, 0x000003E8} the next cycle; read back matches; a write to offset 3 is ignored and reads 0.
6. Send E0 only, assert rst for 1 cycle, then send 1C -> entry is 0x01C, not extended; all outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/ps2_key_mmio.sv
// PS/2 keyboard event port: decodes E0/F0 prefixes into tagged key events,
// queues them in a FIFO and exposes the queue plus display mirror words on a word bus.
//
// state   | meaning
// S_IDLE  | no prefix pending
// S_E0    | E0 seen, extended key expected
// S_F0    | F0 seen, release of a normal key expected
// S_E0F0  | E0 F0 seen, release of an extended key expected
module ps2_key_mmio #(
    parameter int DEPTH        = 16,
    parameter int BASE_ADDR    = 10,
    parameter int NUM_MIRROR   = 2,
    parameter int FILTER_BREAK = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kb_valid,
    input  logic [7:0]              kb_code,
    input  logic                    bus_we,
    input  logic                    bus_re,
    input  logic [31:0]             bus_addr,
    input  logic [31:0]             bus_wd,
    output logic [31:0]             bus_rd,
    output logic [32*NUM_MIRROR-1:0] mirror_out,
    output logic                    key_pending,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    state_t          r_state;
    logic [9:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [31:0]     r_bus_rd;
    logic [31:0]     r_mirror [NUM_MIRROR];

    logic            w_push;
    logic [9:0]      w_ev;
    logic            w_push_ok;
    logic            w_empty;
    logic            w_full;
    logic [31:0]     w_off;
    logic            w_hit_status;
    logic            w_hit_data;
    logic            w_hit_ctrl;
    logic            w_pop;
    logic            w_wr;
    logic            w_flush;
    logic            w_ovf_clr;
    logic            w_ovf_set;
    logic [31:0]     w_rd_next;

    // Event decode is combinational so the push lands on the completing kb_valid edge.
    always_comb begin
        w_push = 1'b0;
        w_ev   = {2'b00, kb_code};
        if (kb_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (kb_code != 8'hE0 && kb_code != 8'hF0) begin
                        w_push = 1'b1;
                    end
                end
                S_E0: begin
                    if (kb_code != 8'hF0) begin
                        w_push = 1'b1;
                        w_ev   = {2'b10, kb_code};
                    end
                end
                S_F0: begin
                    w_push = 1'b1;
                    w_ev   = {2'b01, kb_code};
                end
                default: begin
                    w_push = 1'b1;
                    w_ev   = {2'b11, kb_code};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (kb_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (kb_code == 8'hE0) begin
                        r_state <= S_E0;
                    end else if (kb_code == 8'hF0) begin
                        r_state <= S_F0;
                    end
                end
                S_E0:    r_state <= (kb_code == 8'hF0) ? S_E0F0 : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_push_ok = w_push && !((FILTER_BREAK != 0) && w_ev[8]);

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_off        = bus_addr - 32'(BASE_ADDR);
    assign w_hit_status = (w_off == 32'd0);
    assign w_hit_data   = (w_off == 32'd1);
    assign w_hit_ctrl   = (w_off == 32'd2);

    assign w_pop     = bus_re && w_hit_data && !w_empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign w_wr      = w_push_ok && (!w_full || w_pop);
    assign w_ovf_set = w_push_ok && w_full && !w_pop;
    assign w_flush   = bus_we && w_hit_ctrl && bus_wd[1];
    assign w_ovf_clr = bus_we && w_hit_ctrl && bus_wd[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !w_flush) begin
            r_mem[r_wr_ptr] <= w_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_MIRROR; i++) begin
                r_mirror[i] <= '0;
            end
        end else if (bus_we) begin
            for (int i = 0; i < NUM_MIRROR; i++) begin
                if (w_off == 32'(4 + i)) begin
                    r_mirror[i] <= bus_wd;
                end
            end
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        w_rd_next = '0;
        if (w_hit_status) begin
            w_rd_next = {15'b0, 9'(r_count), 5'b0, r_ovf, w_full, !w_empty};
        end else if (w_hit_data && !w_empty) begin
            w_rd_next = {22'b0, r_mem[r_rd_ptr]};
        end else begin
            for (int i = 0; i < NUM_MIRROR; i++) begin
                if (w_off == 32'(4 + i)) begin
                    w_rd_next = r_mirror[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_rd <= '0;
        end else if (bus_re) begin
            r_bus_rd <= w_rd_next;
        end
    end

    for (genvar g = 0; g < NUM_MIRROR; g++) begin : g_mirror
        assign mirror_out[32*g +: 32] = r_mirror[g];
    end

    assign bus_rd      = r_bus_rd;
    assign key_pending = !w_empty;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_ps2_key_mmio.sv
// Bench for ps2_key_mmio: main instance plus a FILTER_BREAK=1 instance on a shared bus;
// expected events are queued as bytes are sent and checked as DATA reads return.
module tb_ps2_key_mmio;

    localparam int BASE = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        kb_valid = 1'b0;
    logic        kb_valid_f = 1'b0;
    logic [7:0]  kb_code = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wd = '0;
    logic [31:0] bus_rd, bus_rd_f;
    logic [63:0] mirror_out, mirror_out_f;
    logic        key_pending, key_pending_f;
    logic        overflow, overflow_f;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q_exp [$];
    logic [31:0] q_exp_f [$];

    always #5 clk = ~clk;

    ps2_key_mmio #(.DEPTH(16), .BASE_ADDR(BASE), .NUM_MIRROR(2), .FILTER_BREAK(0)) dut (
        .clk(clk), .rst(rst), .kb_valid(kb_valid), .kb_code(kb_code),
        .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr), .bus_wd(bus_wd),
        .bus_rd(bus_rd), .mirror_out(mirror_out), .key_pending(key_pending),
        .overflow(overflow)
    );

    ps2_key_mmio #(.DEPTH(16), .BASE_ADDR(BASE), .NUM_MIRROR(2), .FILTER_BREAK(1)) dut_f (
        .clk(clk), .rst(rst), .kb_valid(kb_valid_f), .kb_code(kb_code),
        .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr), .bus_wd(bus_wd),
        .bus_rd(bus_rd_f), .mirror_out(mirror_out_f), .key_pending(key_pending_f),
        .overflow(overflow_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit to_f);
        kb_code = b;
        if (to_f) kb_valid_f = 1'b1;
        else      kb_valid = 1'b1;
        tick();
        kb_valid = 1'b0;
        kb_valid_f = 1'b0;
    endtask

    task automatic rd(input int off, output logic [31:0] d);
        bus_re = 1'b1;
        bus_addr = 32'(BASE + off);
        tick();
        bus_re = 1'b0;
        d = bus_rd;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        bus_we = 1'b1;
        bus_addr = 32'(BASE + off);
        bus_wd = d;
        tick();
        bus_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (key_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", key_pending); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_vec++; if (bus_rd !== 32'h0) begin n_err++; $display("FAIL reset_bus_rd got %h want 0", bus_rd); end
        n_vec++; if (mirror_out !== 64'h0) begin n_err++; $display("FAIL reset_mirror got %h want 0", mirror_out); end
    endtask

    task automatic test_prefix();
        logic [31:0] d, e;
        send(8'h1C, 0); q_exp.push_back(32'h01C);
        send(8'hF0, 0); send(8'h1C, 0); q_exp.push_back(32'h11C);
        send(8'hE0, 0); send(8'h75, 0); q_exp.push_back(32'h275);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0); q_exp.push_back(32'h375);
        send(8'hE1, 0); q_exp.push_back(32'h0E1);
        n_vec++; if (key_pending !== 1'b1) begin n_err++; $display("FAIL prefix_pending got %b want 1", key_pending); end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            rd(1, d);
            n_vec++; if (d !== e) begin n_err++; $display("FAIL prefix_pop got %h want %h", d, e); end
        end
        rd(0, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL prefix_status got %h want 0", d); end
    endtask

    task automatic test_filter();
        logic [31:0] e;
        send(8'h1C, 1); q_exp_f.push_back(32'h01C);
        send(8'hF0, 1); send(8'h1C, 1);
        send(8'hE0, 1); send(8'h75, 1); q_exp_f.push_back(32'h275);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        bus_re = 1'b1; bus_addr = 32'(BASE); tick(); bus_re = 1'b0;
        n_vec++; if (bus_rd_f !== 32'h0201) begin n_err++; $display("FAIL filter_status got %h want 00000201", bus_rd_f); end
        while (q_exp_f.size() > 0) begin
            e = q_exp_f.pop_front();
            bus_re = 1'b1; bus_addr = 32'(BASE + 1); tick(); bus_re = 1'b0;
            n_vec++; if (bus_rd_f !== e) begin n_err++; $display("FAIL filter_pop got %h want %h", bus_rd_f, e); end
        end
        n_vec++; if (key_pending_f !== 1'b0) begin n_err++; $display("FAIL filter_empty got %b want 0", key_pending_f); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        for (int i = 1; i <= 17; i++) begin
            send(8'(i), 0);
            if (i <= 16) q_exp.push_back(32'(i));
        end
        rd(0, d);
        n_vec++; if (d !== 32'h1007) begin n_err++; $display("FAIL ovf_status got %h want 00001007", d); end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            rd(1, d);
            n_vec++; if (d !== e) begin n_err++; $display("FAIL ovf_pop got %h want %h", d, e); end
        end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        wr(2, 32'h1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        for (int i = 0; i < 16; i++) begin
            send(8'h20 + 8'(i), 0);
            q_exp.push_back(32'h20 + 32'(i));
        end
        // push 0x30 and pop on the same edge while full
        kb_code = 8'h30; kb_valid = 1'b1;
        bus_re = 1'b1; bus_addr = 32'(BASE + 1);
        tick();
        kb_valid = 1'b0; bus_re = 1'b0;
        q_exp.push_back(32'h30);
        e = q_exp.pop_front();
        n_vec++; if (bus_rd !== e) begin n_err++; $display("FAIL simul_full_pop got %h want %h", bus_rd, e); end
        rd(0, d);
        n_vec++; if (d !== 32'h1003) begin n_err++; $display("FAIL simul_full_status got %h want 00001003", d); end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            rd(1, d);
            n_vec++; if (d !== e) begin n_err++; $display("FAIL simul_drain got %h want %h", d, e); end
        end
        // empty: push and read together
        kb_code = 8'h40; kb_valid = 1'b1;
        bus_re = 1'b1; bus_addr = 32'(BASE + 1);
        tick();
        kb_valid = 1'b0; bus_re = 1'b0;
        n_vec++; if (bus_rd !== 32'h0) begin n_err++; $display("FAIL simul_empty_rd got %h want 0", bus_rd); end
        rd(0, d);
        n_vec++; if (d !== 32'h0101) begin n_err++; $display("FAIL simul_empty_status got %h want 00000101", d); end
        rd(1, d);
        n_vec++; if (d !== 32'h040) begin n_err++; $display("FAIL simul_empty_pop got %h want 00000040", d); end
    endtask

    task automatic test_control_races();
        logic [31:0] d;
        for (int i = 0; i < 16; i++) send(8'h50, 0);
        // overflow set and clear on the same edge: set wins
        kb_code = 8'h55; kb_valid = 1'b1;
        bus_we = 1'b1; bus_addr = 32'(BASE + 2); bus_wd = 32'h1;
        tick();
        kb_valid = 1'b0; bus_we = 1'b0;
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL race_ovf got %b want 1", overflow); end
        wr(2, 32'h3);
        rd(0, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL race_flush_clear got %h want 0", d); end
        // push and flush on the same edge: flush wins
        kb_code = 8'h66; kb_valid = 1'b1;
        bus_we = 1'b1; bus_addr = 32'(BASE + 2); bus_wd = 32'h2;
        tick();
        kb_valid = 1'b0; bus_we = 1'b0;
        rd(0, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL race_push_flush got %h want 0", d); end
        rd(2, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_read got %h want 0", d); end
    endtask

    task automatic test_mirror();
        logic [31:0] d;
        wr(4, 32'h0000_03E8);
        wr(5, 32'h0000_0005);
        n_vec++; if (mirror_out !== 64'h0000_0005_0000_03E8) begin n_err++; $display("FAIL mirror_out got %h want 00000005000003e8", mirror_out); end
        rd(4, d);
        n_vec++; if (d !== 32'h3E8) begin n_err++; $display("FAIL mirror0_rd got %h want 000003e8", d); end
        rd(5, d);
        n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL mirror1_rd got %h want 00000005", d); end
        wr(3, 32'hDEAD_BEEF);
        rd(3, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL unused_rd got %h want 0", d); end
        // same-edge read and write returns the pre-write value
        bus_we = 1'b1; bus_re = 1'b1; bus_addr = 32'(BASE + 5); bus_wd = 32'h77;
        tick();
        bus_we = 1'b0; bus_re = 1'b0;
        n_vec++; if (bus_rd !== 32'h5) begin n_err++; $display("FAIL rw_same got %h want 00000005", bus_rd); end
        n_vec++; if (mirror_out[63:32] !== 32'h77) begin n_err++; $display("FAIL rw_same_wr got %h want 00000077", mirror_out[63:32]); end
        rd(4, d);
    endtask

    task automatic test_reset_mid_prefix();
        logic [31:0] d;
        send(8'h12, 0);
        send(8'hE0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (key_pending !== 1'b0) begin n_err++; $display("FAIL mid_rst_pending got %b want 0", key_pending); end
        n_vec++; if (bus_rd !== 32'h0) begin n_err++; $display("FAIL mid_rst_bus_rd got %h want 0", bus_rd); end
        n_vec++; if (mirror_out !== 64'h0) begin n_err++; $display("FAIL mid_rst_mirror got %h want 0", mirror_out); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got %b want 0", overflow); end
        send(8'h1C, 0); q_exp.push_back(32'h01C);
        rd(1, d);
        n_vec++; if (d !== q_exp.pop_front()) begin n_err++; $display("FAIL mid_rst_entry got %h want 0000001c", d); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        test_reset();
        test_prefix();
        test_filter();
        test_overflow();
        test_back_to_back();
        test_control_races();
        test_mirror();
        test_reset_mid_prefix();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
